// File: rtl/ram8_arb_pkg.sv
// Shared definitions for the two-requester word-store arbiter: state encoding,
// requester IDs, default geometry and the round-robin pick.
package ram8_arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // On a tie the requester that was not granted last takes the slot.
  function automatic logic pick_winner(input logic a_req, input logic b_req,
                                       input logic last_grant);
    if (a_req && b_req) return (last_grant == ID_A) ? ID_B : ID_A;
    else if (a_req)     return ID_A;
    else                return ID_B;
  endfunction

endpackage

// File: rtl/ram8_arbiter_if.sv
// Requester-side bus of the arbiter: two req/ack ports plus shared read data.
interface ram8_arbiter_if
  import ram8_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  // Handshake: a requester raises x_req with x_we/x_addr/x_wdata and holds it
  // until x_ack pulses for one cycle; rdata is meaningful only while an ack is
  // high, and req still high the cycle after ack counts as a fresh request.
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [WIDTH-1:0]  a_wdata;
  logic              a_ack;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_wdata;
  logic              b_ack;

  logic [WIDTH-1:0]  rdata;
  logic              busy;
  state_t            dbg_state;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_ack, b_ack, rdata, busy, dbg_state
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_ack, b_ack, rdata, busy, dbg_state
  );

endinterface

// File: rtl/ram8_arbiter_word.sv
// One storage word: a load-enabled register cleared by the async reset.
module reg_word
  import ram8_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (load) r_q <= in;
  end

  assign out = r_q;

endmodule

// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter in front of a small register-based store;
// each granted access occupies one ACCESS cycle, writes commit as it ends.
module ram8_arbiter
  import ram8_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  ram8_arbiter_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_a_ack;
  logic              r_b_ack;
  logic              r_busy;
  logic [WIDTH-1:0]  r_rdata;

  logic [WIDTH-1:0]  w_word [DEPTH];
  logic [DEPTH-1:0]  w_load;
  logic              w_any_req;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_wdata;

  assign w_any_req = bus.a_req | bus.b_req;
  assign w_win     = pick_winner(bus.a_req, bus.b_req, r_last_grant);
  assign w_we      = (w_win == ID_A) ? bus.a_we    : bus.b_we;
  assign w_addr    = (w_win == ID_A) ? bus.a_addr  : bus.b_addr;
  assign w_wdata   = (w_win == ID_A) ? bus.a_wdata : bus.b_wdata;

  // Write strobe comes from the latched request only, so bus changes during
  // ACCESS cannot redirect the write.
  always_comb begin
    w_load = '0;
    if (r_state == ST_ACCESS && r_we) w_load[r_addr] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_load[i]),
      .in    (r_wdata),
      .out   (w_word[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ID_B;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_busy       <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state      <= ST_ACCESS;
            r_last_grant <= w_win;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_a_ack      <= (w_win == ID_A);
            r_b_ack      <= (w_win == ID_B);
            r_busy       <= 1'b1;
            // Captured before the write lands, so rdata shows the old word.
            r_rdata      <= w_word[w_addr];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign bus.a_ack     = r_a_ack;
  assign bus.b_ack     = r_b_ack;
  assign bus.busy      = r_busy;
  assign bus.rdata     = r_rdata;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: directed scenarios plus random traffic, checked
// against a transaction model (word array + last-grant rule) every cycle.
module tb_ram8_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  ram8_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram8_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_last;      // 0 = A granted last, 1 = B
  logic             m_in_access;
  logic             m_we;
  logic [2:0]       m_addr;
  logic [WIDTH-1:0] m_wdata;
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_last      = 1'b1;
    m_in_access = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic req, input logic we, input logic [2:0] addr,
                         input logic [WIDTH-1:0] d);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [2:0] addr,
                         input logic [WIDTH-1:0] d);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
  endtask

  task automatic idle_inputs();
    drive_a(1'b0, 1'b0, 3'd0, '0);
    drive_b(1'b0, 1'b0, 3'd0, '0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_a_ack", bus.a_ack, 0);
    check("rst_b_ack", bus.b_ack, 0);
    check("rst_busy",  bus.busy,  0);
    check("rst_rdata", bus.rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Predict what the coming edge does from the current inputs, advance one
  // cycle, then compare every output. Returns the observed winner on an ack.
  task automatic step(output logic acked, output logic who);
    logic exp_a, exp_b, exp_busy, win;
    exp_a = 1'b0; exp_b = 1'b0; exp_busy = 1'b0; win = 1'b0;
    if (m_in_access) begin
      if (m_we) m_mem[m_addr] = m_wdata;
      m_in_access = 1'b0;
    end else if (bus.a_req || bus.b_req) begin
      if (bus.a_req && bus.b_req) win = ~m_last;
      else                        win = bus.b_req;
      m_we        = win ? bus.b_we    : bus.a_we;
      m_addr      = win ? bus.b_addr  : bus.a_addr;
      m_wdata     = win ? bus.b_wdata : bus.a_wdata;
      m_last      = win;
      m_in_access = 1'b1;
      exp_busy    = 1'b1;
      exp_a       = ~win;
      exp_b       = win;
      exp_q.push_back(m_mem[m_addr]);
    end
    @(posedge clk);
    #1;
    check("a_ack", bus.a_ack, exp_a);
    check("b_ack", bus.b_ack, exp_b);
    check("busy",  bus.busy,  exp_busy);
    if (exp_busy && exp_q.size() > 0) check("rdata", bus.rdata, exp_q.pop_front());
    else                              check("rdata_idle", bus.rdata, 0);
    acked = bus.a_ack | bus.b_ack;
    who   = bus.b_ack;
  endtask

  task automatic run(input int n);
    logic ak, wh;
    for (int i = 0; i < n; i++) step(ak, wh);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ak, wh;
    int   n_acks;

    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    reset_dut();
    run(2);

    // single A write then read back
    drive_a(1'b1, 1'b1, 3'd3, 16'h1234);
    step(ak, wh);
    drive_a(1'b0, 1'b0, 3'd0, '0);
    run(1);
    drive_a(1'b1, 1'b0, 3'd3, '0);
    step(ak, wh);
    idle_inputs();
    run(2);

    // simultaneous writes: A wins the tie first, B two cycles later
    drive_a(1'b1, 1'b1, 3'd1, 16'hAAAA);
    drive_b(1'b1, 1'b1, 3'd2, 16'h5555);
    step(ak, wh);
    drive_a(1'b0, 1'b0, 3'd0, '0);
    run(1);
    step(ak, wh);
    check("tie_second_is_b", {31'd0, ak & wh}, 1);
    idle_inputs();
    run(1);
    drive_a(1'b1, 1'b0, 3'd1, '0); step(ak, wh); idle_inputs(); run(1);
    drive_b(1'b1, 1'b0, 3'd2, '0); step(ak, wh); idle_inputs(); run(1);

    // both held continuously from reset: grants alternate A, B, A, ...
    reset_dut();
    drive_a(1'b1, 1'b1, 3'd4, 16'h0A0A);
    drive_b(1'b1, 1'b0, 3'd4, '0);
    n_acks = 0;
    for (int i = 0; i < 16; i++) begin
      step(ak, wh);
      if (ak) begin
        check("rr_alt", {31'd0, wh}, n_acks % 2);
        n_acks++;
      end
    end
    check("rr_count", n_acks, 8);
    idle_inputs();
    run(1);

    // top address write, then reads of addr 7 and addr 0
    drive_a(1'b1, 1'b1, 3'd7, 16'hFFFF); step(ak, wh); idle_inputs(); run(1);
    drive_a(1'b1, 1'b0, 3'd7, '0);       step(ak, wh); idle_inputs(); run(1);
    drive_b(1'b1, 1'b0, 3'd0, '0);       step(ak, wh); idle_inputs(); run(1);

    // bus changes during ACCESS must not alter the latched transaction
    drive_a(1'b1, 1'b1, 3'd4, 16'h4444);
    step(ak, wh);
    drive_a(1'b0, 1'b1, 3'd6, 16'h6666);
    run(1);
    idle_inputs();
    for (int a = 4; a < 7; a += 2) begin
      drive_a(1'b1, 1'b0, a[2:0], '0); step(ak, wh); idle_inputs(); run(1);
    end

    // reset in the middle of a B write: aborted, word stays 0, A wins next tie
    drive_b(1'b1, 1'b1, 3'd5, 16'h0F0F);
    step(ak, wh);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("abort_b_ack", bus.b_ack, 0);
    check("abort_busy",  bus.busy,  0);
    check("abort_rdata", bus.rdata, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(1'b1, 1'b0, 3'd5, '0);
    drive_b(1'b1, 1'b0, 3'd5, '0);
    step(ak, wh);
    check("post_abort_tie_a", {30'd0, ak, wh}, 2);
    idle_inputs();
    run(2);

    // random traffic, inputs allowed to change in any cycle
    for (int i = 0; i < 400; i++) begin
      drive_a($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), 16'($urandom));
      drive_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), 16'($urandom));
      step(ak, wh);
    end
    idle_inputs();
    run(2);

    // sweep every word through reads
    for (int a = 0; a < DEPTH; a++) begin
      drive_b(1'b1, 1'b0, a[2:0], '0); step(ak, wh); idle_inputs(); run(1);
    end

    check("scoreboard_drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram8_arbiter.md
RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage words; address width is ADDR_W = log2(DEPTH) = 3.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port a_req  input  1  requester A access request, held until a_ack.
REQ-006 Port a_we  input  1  requester A write enable (1 = write, 0 = read).
REQ-007 Port a_addr  input  ADDR_W  requester A word address.
REQ-008 Port a_wdata  input  WIDTH  requester A write data.
REQ-009 Port a_ack  output  1  one-cycle completion pulse to A.
REQ-010 Ports b_req, b_we, b_addr, b_wdata, b_ack: identical to the A ports, for requester B.
REQ-011 Port rdata  output  WIDTH  addressed word contents, valid while a_ack or b_ack is high.
REQ-012 Port busy  output  1  high while the FSM is in ACCESS.

Function
REQ-013 The block SHALL hold DEPTH words of WIDTH bits, each word a load-enabled register shared by A and B.
REQ-014 FSM states SHALL be IDLE and ACCESS.
- IDLE -> ACCESS when a_req or b_req is high at the clock edge.
- ACCESS -> IDLE unconditionally after one cycle.
REQ-015 On the IDLE->ACCESS edge, the block SHALL latch the winner ID and that requester's we, addr and wdata.
REQ-016 Arbitration SHALL be round-robin.
- Single request: that requester wins.
- Both requesting: the requester not granted last wins.
- last_grant updates only on IDLE->ACCESS.
REQ-017 In ACCESS, the winner's ack SHALL be high for exactly that cycle; the other ack SHALL stay low.
REQ-018 In ACCESS, rdata SHALL equal the latched word's value before any write in that transaction.
REQ-019 A latched write SHALL update exactly one word, at the clock edge ending ACCESS; all other words SHALL hold.
REQ-020 Latency: request seen at edge N -> ack during cycle N..N+1 -> write visible from edge N+1.
- Maximum throughput: one transaction per 2 cycles.
REQ-021 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-022 Requester inputs changing while in ACCESS SHALL have no effect on the current transaction.
REQ-023 Outside ACCESS: a_ack = 0, b_ack = 0, busy = 0, rdata = 0.

Reset
REQ-024 When rst_n is low, the block SHALL asynchronously set:
- state = IDLE;
- all storage words = 0;
- a_ack, b_ack, busy, rdata = 0;
- last_grant = B, so that A wins the first tie.
REQ-025 Reset asserted during ACCESS SHALL abort the transaction: no write occurs and no ack is produced.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur at the next rising edge.

Structure
REQ-027 A shared package ram8_arb_pkg SHALL hold the FSM state encoding, requester ID constants (ID_A = 0, ID_B = 1) and the WIDTH/DEPTH defaults.
REQ-028 Storage words SHALL be instances of sub-module reg_word.
- Ports: clk, rst_n, load, in[WIDTH], out[WIDTH].
- Instantiated DEPTH times; load is driven by a decoded write strobe.

Verification
REQ-029 Reset, then A writes 0x1234 to addr 3 -> a_ack one cycle later, b_ack = 0; a later A read of addr 3 -> rdata = 0x1234.
REQ-030 A and B request together (A write 0xAAAA to addr 1, B write 0x5555 to addr 2) -> A acked first, B acked 2 cycles later; both words hold their values afterwards.
REQ-031 A and B hold req continuously for 8 transactions -> acks alternate A, B, A, B...; no requester is acked twice in a row.
REQ-032 Write 0xFFFF to addr 7, then read addr 7 and addr 0 -> rdata = 0xFFFF, then 0x0000; words 0..6 unchanged.
REQ-033 rst_n pulled low mid-ACCESS of a B write of 0x0F0F to addr 5 -> no b_ack; addr 5 reads 0 after reset; the next tie goes to A.
REQ-034 A changes a_addr and a_wdata during ACCESS -> the originally latched address and data are used.
